// File: rtl/up_cmd_master_pkg.sv
// Shared types and sizing helpers for the UP command master.
// Optional request timeout is enabled with UP_CMD_MASTER_TIMEOUT_EN.
package up_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Counter must be able to hold the terminal value itself
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(TIMEOUT_CYCLES_DEFAULT);

endpackage

// File: rtl/up_cmd_timeout.sv
// Clearable saturating cycle counter; expired_c flags that LIMIT was reached.
// Only instantiated when UP_CMD_MASTER_TIMEOUT_EN is defined.
module up_cmd_timeout
    import up_cmd_master_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    logic [CNT_W-1:0] count;

    assign expired_c = (count == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/up_cmd_master.sv
// UP bus initiator: one valid/ready command becomes one UP read or write.
// Define UP_CMD_MASTER_TIMEOUT_EN to abort requests after TIMEOUT_CYCLES.
module up_cmd_master
    import up_cmd_master_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [BUS_WIDTH*8-1:0]   cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [BUS_WIDTH*8-1:0]   rsp_rdata,
    output logic                     rsp_error,
    output logic                     up_rreq,
    input  logic                     up_rack,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [BUS_WIDTH*8-1:0]   up_rdata,
    output logic                     up_wreq,
    input  logic                     up_wack,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [BUS_WIDTH*8-1:0]   up_wdata
);

    state_t state;
    logic   busy;
    logic   timeout_hit;

    assign busy = (state == READ) || (state == WRITE);

`ifdef UP_CMD_MASTER_TIMEOUT_EN
    // Held clear outside READ/WRITE, so every request starts from zero
    up_cmd_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (!busy),
        .inc       (busy),
        .expired_c (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready = rstn && (state == IDLE);

    // Acks only count once our own request is visible; the ack is checked
    // before the timeout so a same-cycle ack completes normally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            up_rreq   <= 1'b0;
            up_raddr  <= '0;
            up_wreq   <= 1'b0;
            up_waddr  <= '0;
            up_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            up_waddr <= cmd_addr;
                            up_wdata <= cmd_wdata;
                            state    <= WRITE;
                        end else begin
                            up_raddr <= cmd_addr;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (up_rreq && up_rack) begin
                        up_rreq   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= up_rdata;
                        rsp_error <= 1'b0;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        up_rreq   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                        state     <= RESP;
                    end else begin
                        up_rreq <= 1'b1;
                    end
                end
                WRITE: begin
                    if (up_wreq && up_wack) begin
                        up_wreq   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        up_wreq   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                        state     <= RESP;
                    end else begin
                        up_wreq <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
